mem_store_monitor: RTL and testbench

MEM_STORE_MONITOR -- requirements
Module: mem_store_monitor

---
 rtl/mem_store_monitor.sv | 80 ++++++++
 tb/tb_mem_store_monitor.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_store_monitor.sv
// mem_store_monitor: passive store-bus monitor ending a run in PASS, FAIL or TIMEOUT, with a 4-deep store log
module mem_store_monitor #(
   parameter logic [31:0] PASS_ADR  = 32'd84,
   parameter logic [31:0] PASS_DATA = 32'd7,
   parameter logic [31:0] ALLOW_ADR = 32'd80,
   parameter logic [15:0] TIMEOUT   = 16'd1000,
   parameter int          LOG_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   input  logic [1:0]  log_idx,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        timeout,
   output logic [15:0] store_count,
   output logic [31:0] fail_adr,
   output logic [31:0] fail_data,
   output logic [31:0] log_adr,
   output logic [31:0] log_data
);
   typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;
   state_t      state;
   logic [15:0] cyc;
   logic [1:0]  wptr;
   logic [31:0] log_a [LOG_DEPTH];
   logic [31:0] log_d [LOG_DEPTH];
   logic        hit, bad;
   logic [1:0]  ridx;
   assign hit      = dataadr == PASS_ADR && writedata == PASS_DATA;
   assign bad      = !hit && dataadr != ALLOW_ADR;
   // index 0 is the newest entry, so read backwards from the write pointer
   assign ridx     = wptr - 2'd1 - log_idx;
   assign log_adr  = log_a[ridx];
   assign log_data = log_d[ridx];
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_RUN;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         timeout     <= 1'b0;
         store_count <= 16'd0;
         cyc         <= 16'd0;
         fail_adr    <= 32'd0;
         fail_data   <= 32'd0;
         wptr        <= 2'd0;
         for (int i = 0; i < LOG_DEPTH; i++) begin
            log_a[i] <= 32'd0;
            log_d[i] <= 32'd0;
         end
      end else if (state == S_RUN) begin
         cyc <= cyc + 16'd1;
         if (memwrite) begin
            store_count <= store_count == 16'hFFFF ? store_count : store_count + 16'd1;
            log_a[wptr] <= dataadr;
            log_d[wptr] <= writedata;
            wptr        <= wptr + 2'd1;
            if (hit) begin
               state <= S_PASS;
               pass  <= 1'b1;
               done  <= 1'b1;
            end else if (bad) begin
               state     <= S_FAIL;
               fail      <= 1'b1;
               done      <= 1'b1;
               fail_adr  <= dataadr;
               fail_data <= writedata;
            end
         end else if (cyc == TIMEOUT - 16'd1) begin
            state   <= S_TIMEOUT;
            timeout <= 1'b1;
            done    <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mem_store_monitor.sv
// tb_mem_store_monitor: random and directed checks of mem_store_monitor against a queue-based reference model
module tb_mem_store_monitor;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memwrite = 1'b0;
   logic [31:0] dataadr = 32'd0;
   logic [31:0] writedata = 32'd0;
   logic [1:0]  log_idx = 2'd0;
   logic        done, pass, fail, timeout;
   logic [15:0] store_count;
   logic [31:0] fail_adr, fail_data, log_adr, log_data;
   logic        t_done, t_pass, t_fail, t_timeout;
   logic [15:0] t_store_count;
   logic [31:0] t_fail_adr, t_fail_data, t_log_adr, t_log_data;
   int total = 0;
   int bad = 0;

   mem_store_monitor dut (
      .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
      .log_idx(log_idx), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
      .store_count(store_count), .fail_adr(fail_adr), .fail_data(fail_data),
      .log_adr(log_adr), .log_data(log_data));

   mem_store_monitor #(.TIMEOUT(16'd10)) dut_t (
      .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
      .log_idx(log_idx), .done(t_done), .pass(t_pass), .fail(t_fail), .timeout(t_timeout),
      .store_count(t_store_count), .fail_adr(t_fail_adr), .fail_data(t_fail_data),
      .log_adr(t_log_adr), .log_data(t_log_data));

   always #5 clk = ~clk;

   // reference model: outcome, counters and the stores seen, newest at the back
   int          m_end;
   int          m_cnt;
   int          m_cyc;
   logic [31:0] m_fa, m_fd;
   logic [31:0] q_a [$];
   logic [31:0] q_d [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_end = 0; m_cnt = 0; m_cyc = 0; m_fa = 0; m_fd = 0;
      q_a.delete(); q_d.delete();
   endtask

   task automatic m_step(input logic mw, input logic [31:0] a, input logic [31:0] d);
      if (m_end != 0) return;
      if (mw) begin
         if (m_cnt < 65535) m_cnt++;
         q_a.push_back(a); q_d.push_back(d);
         if (q_a.size() > 4) begin void'(q_a.pop_front()); void'(q_d.pop_front()); end
         if (a == 84 && d == 7) m_end = 1;
         else if (a != 80) begin m_end = 2; m_fa = a; m_fd = d; end
      end else if (m_cyc == 999) m_end = 3;
      m_cyc++;
   endtask

   task automatic compare_all();
      for (int i = 0; i < 4; i++) begin
         log_idx = 2'(i);
         #1;
         chk($sformatf("log_adr[%0d]", i), log_adr, i < q_a.size() ? q_a[q_a.size()-1-i] : 32'd0);
         chk($sformatf("log_data[%0d]", i), log_data, i < q_d.size() ? q_d[q_d.size()-1-i] : 32'd0);
      end
      chk("done", 32'(done), 32'(m_end != 0));
      chk("pass", 32'(pass), 32'(m_end == 1));
      chk("fail", 32'(fail), 32'(m_end == 2));
      chk("timeout", 32'(timeout), 32'(m_end == 3));
      chk("store_count", 32'(store_count), 32'(m_cnt));
      chk("fail_adr", fail_adr, m_fa);
      chk("fail_data", fail_data, m_fd);
   endtask

   task automatic tick(input logic mw, input logic [31:0] a, input logic [31:0] d);
      memwrite = mw; dataadr = a; writedata = d;
      @(posedge clk);
      #1;
      m_step(mw, a, d);
      compare_all();
   endtask

   // a terminating store is presented during reset to show reset wins
   task automatic do_reset();
      reset = 1'b1; memwrite = 1'b1; dataadr = 32'd84; writedata = 32'd7;
      @(posedge clk);
      #1;
      reset = 1'b0; memwrite = 1'b0;
      m_reset();
      compare_all();
   endtask

   initial begin
      logic [31:0] a, d;
      m_reset();
      do_reset();
      tick(1, 80, 5); tick(1, 80, 9); tick(1, 84, 7);
      chk("d24_pass", 32'(pass), 1);
      chk("d24_count", 32'(store_count), 3);
      log_idx = 2'd0; #1;
      chk("d24_log0_adr", log_adr, 84);
      chk("d24_log0_data", log_data, 7);
      log_idx = 2'd2; #1;
      chk("d24_log2_adr", log_adr, 80);
      chk("d24_log2_data", log_data, 5);
      tick(1, 88, 1);
      chk("d29_pass", 32'(pass), 1);
      chk("d29_fail_adr", fail_adr, 0);
      do_reset();
      chk("d29_reset_count", 32'(store_count), 0);
      tick(1, 88, 7);
      chk("d25_fail", 32'(fail), 1);
      chk("d25_fail_adr", fail_adr, 88);
      do_reset();
      tick(1, 84, 6);
      chk("d26_fail_data", fail_data, 6);
      do_reset();
      for (int i = 0; i < 6; i++) tick(1, 80, 32'(100 + i));
      tick(1, 84, 7);
      chk("d28_count", 32'(store_count), 7);
      log_idx = 2'd3; #1;
      chk("d28_log3_data", log_data, 103);
      do_reset();
      for (int i = 0; i < 9; i++) tick(0, 0, 0);
      chk("d27_not_yet", 32'(t_timeout), 0);
      tick(0, 0, 0);
      chk("d27_timeout", 32'(t_timeout), 1);
      chk("d27_done", 32'(t_done), 1);
      chk("d27_pass", 32'(t_pass), 0);
      chk("d27_fail", 32'(t_fail), 0);
      tick(1, 88, 3);
      chk("d27_sticky", 32'(t_timeout), 1);
      chk("d27_frozen_count", 32'(t_store_count), 0);
      do_reset();
      for (int i = 0; i < 9; i++) tick(0, 0, 0);
      tick(1, 84, 7);
      chk("store_beats_timeout_pass", 32'(t_pass), 1);
      chk("store_beats_timeout_to", 32'(t_timeout), 0);
      for (int r = 0; r < 40; r++) begin
         do_reset();
         for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 9))
               0: a = 84;
               1: a = 88;
               2: a = $urandom;
               default: a = 80;
            endcase
            d = $urandom_range(0, 3) == 0 ? 32'd7 : $urandom_range(0, 12);
            tick($urandom_range(0, 2) != 0, a, d);
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
